// File: rtl/ps2_key_fifo_pkg.sv
// Shared definitions for the PS/2 key event FIFO.
// Key-word bit positions, queued event layout and drop counter limit.
`timescale 1ns/1ps
package ps2_key_pkg;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef struct packed {
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_key_fifo_if.sv
// Bus bundle between the CPU side and ps2_key_fifo.
// master: key word, rd/clr strobes in; slave: head entry and status out.
`timescale 1ns/1ps
interface ps2_key_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [10:0] ps2_key;
  logic        rd;
  logic        clr;
  logic [9:0]  dout;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  modport master (
    output ps2_key, rd, clr,
    input  dout, empty, full, count,
    input  overflow, drop_cnt
  );

  modport slave (
    input  ps2_key, rd, clr,
    output dout, empty, full, count,
    output overflow, drop_cnt
  );

endinterface

// File: rtl/ps2_key_fifo_fifo.sv
// First-word-fall-through FIFO with a registered head output.
// Ports: push/din write, pop advance, dout head, empty/full/count status.
`timescale 1ns/1ps
module sync_fifo_fwft #(
  parameter int DEPTH = 16,
  parameter int W     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          empty_w, full_w;
  logic          push_ok, pop_ok;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty_w;
  // A full FIFO still takes a push when a pop frees the slot.
  assign push_ok = push & (~full_w | pop_ok);
  assign rd_nxt  = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_nxt;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // Head register: next stored entry, or the incoming
    // word when it becomes the new head. Drained: hold.
    if (pop_ok) begin
      if (count_q > (AW+1)'(1))
        dout_d = mem_q[rd_nxt];
      else if (push_ok)
        dout_d = din;
    end else if (push_ok && empty_w) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign empty = empty_w;
  assign full  = full_w;
  assign count = count_q;

endmodule

// File: rtl/ps2_key_fifo.sv
// Turns toggle-flagged hps_io key words into queued key events.
// Ports: clk_sys, reset, bus (slave): ps2_key/rd/clr in; dout/status out.
`timescale 1ns/1ps
module ps2_key_fifo
  import ps2_key_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk_sys,
  input  logic           reset,
  ps2_key_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [10:0] key_q, key_d;
  logic        tog_q, tog_d;
  logic        armed_q, armed_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_q, drop_d;
  logic [7:0]  drop_base;
  logic        evt, push, drop;
  ps2_evt_t    evt_word;
  logic [9:0]  fifo_dout;
  logic        fifo_empty, fifo_full;
  logic [AW:0] fifo_count;

  always_comb begin
    key_d   = bus.ps2_key;
    armed_d = 1'b1;
    tog_d   = tog_q;
    evt     = 1'b0;
    // First edge out of reset only samples the toggle,
    // so a stale toggle level never yields an event.
    if (!armed_q) begin
      tog_d = bus.ps2_key[KEY_TOGGLE];
    end else if (key_q[KEY_TOGGLE] != tog_q) begin
      evt   = 1'b1;
      tog_d = key_q[KEY_TOGGLE];
    end
  end

  always_comb begin
    evt_word.pressed  = key_q[KEY_PRESSED];
    evt_word.extended = key_q[KEY_EXT];
    evt_word.code     = key_q[7:0];
  end

  // Full implies non-empty, so rd alone means a real pop.
  assign push = evt & (~fifo_full | bus.rd);
  assign drop = evt & fifo_full & ~bus.rd;

  always_comb begin
    // A drop in the clearing cycle counts from zero.
    drop_base = bus.clr ? 8'h00 : drop_q;
    drop_d    = drop_base;
    ovf_d     = ovf_q & ~bus.clr;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_base != DROP_MAX)
        drop_d = drop_base + 8'h01;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      key_q   <= '0;
      tog_q   <= 1'b0;
      armed_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      key_q   <= key_d;
      tog_q   <= tog_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .W     (10)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (push),
    .din   (evt_word),
    .pop   (bus.rd),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign bus.dout     = fifo_dout;
  assign bus.empty    = fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.count    = fifo_count;
  assign bus.overflow = ovf_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo.
// Scenario tasks with inline expected-value checks.
`timescale 1ns/1ps
module tb_ps2_key_fifo;

  localparam int DEPTH = 16;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic tog     = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  ps2_key_fifo_if #(.DEPTH(DEPTH)) bus ();

  ps2_key_fifo #(.DEPTH(DEPTH)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_key(input logic p, input logic e,
                          input logic [7:0] code);
    tog = ~tog;
    bus.ps2_key = {tog, p, e, code};
    tick(2);
  endtask

  task automatic pop();
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
  endtask

  task automatic test_reset();
    tog = 1'b1;
    bus.ps2_key = 11'h400;
    bus.rd  = 1'b0;
    bus.clr = 1'b0;
    reset   = 1'b1;
    tick(2);
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_empty: got %b want 1", bus.empty);
    end
    checks++;
    if (bus.full !== 1'b0) begin
      errors++;
      $display("FAIL rst_full: got %b want 0", bus.full);
    end
    checks++;
    if (bus.count !== 5'd0) begin
      errors++;
      $display("FAIL rst_count: got %0d want 0", bus.count);
    end
    checks++;
    if (bus.dout !== 10'h000) begin
      errors++;
      $display("FAIL rst_dout: got %h want 000", bus.dout);
    end
    checks++;
    if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_diag: got %b/%0d want 0/0",
               bus.overflow, bus.drop_cnt);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (bus.empty !== 1'b1) begin
        errors++;
        $display("FAIL arm_no_evt cyc%0d: got empty=%b want 1",
                 i, bus.empty);
      end
    end
  endtask

  task automatic test_single();
    tog = ~tog;
    bus.ps2_key = {tog, 1'b1, 1'b0, 8'h1C};
    tick(1);
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL single_early: got empty=%b want 1", bus.empty);
    end
    tick(1);
    checks++;
    if (bus.empty !== 1'b0 || bus.dout !== 10'h21C) begin
      errors++;
      $display("FAIL single_head: got %b/%h want 0/21c",
               bus.empty, bus.dout);
    end
    pop();
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
      errors++;
      $display("FAIL single_pop: got %b/%0d want 1/0",
               bus.empty, bus.count);
    end
    pop();
    checks++;
    if (bus.count !== 5'd0 || bus.dout !== 10'h21C) begin
      errors++;
      $display("FAIL empty_rd: got %0d/%h want 0/21c",
               bus.count, bus.dout);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) send_key(1'b1, 1'b0, 8'(i));
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
      errors++;
      $display("FAIL fill_full: got %b/%0d want 1/16",
               bus.full, bus.count);
    end
    checks++;
    if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL fill_drop: got %b/%0d want 1/1",
               bus.overflow, bus.drop_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.dout !== {2'b10, 8'(i)}) begin
        errors++;
        $display("FAIL fill_order %0d: got %h want %h",
                 i, bus.dout, {2'b10, 8'(i)});
      end
      pop();
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
      errors++;
      $display("FAIL fill_drain: got %b/%0d want 1/0",
               bus.empty, bus.count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    for (int i = 0; i < 16; i++)
      send_key(1'b1, 1'b0, 8'(8'h20 + i));
    tog = ~tog;
    bus.ps2_key = {tog, 1'b1, 1'b0, 8'h55};
    tick(1);
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    checks++;
    if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count: got %0d/%b want 16/1",
               bus.count, bus.full);
    end
    checks++;
    if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_diag: got %b/%0d want 0/0",
               bus.overflow, bus.drop_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(8'h21 + i) : 8'h55;
      checks++;
      if (bus.dout !== {2'b10, exp}) begin
        errors++;
        $display("FAIL b2b_order %0d: got %h want %h",
                 i, bus.dout, {2'b10, exp});
      end
      pop();
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain: got empty=%b want 1", bus.empty);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 16; i++) send_key(1'b0, 1'b0, 8'(i));
    for (int i = 0; i < 300; i++) begin
      send_key(1'b0, 1'b1, 8'hAA);
      if (i == 253) begin
        checks++;
        if (bus.drop_cnt !== 8'd254) begin
          errors++;
          $display("FAIL sat_254: got %0d want 254", bus.drop_cnt);
        end
      end
    end
    checks++;
    if (bus.drop_cnt !== 8'd255 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_255: got %0d/%b want 255/1",
               bus.drop_cnt, bus.overflow);
    end
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr: got %b/%0d want 0/0",
               bus.overflow, bus.drop_cnt);
    end
    checks++;
    if (bus.count !== 5'd16) begin
      errors++;
      $display("FAIL clr_count: got %0d want 16", bus.count);
    end
    tog = ~tog;
    bus.ps2_key = {tog, 1'b1, 1'b1, 8'h77};
    tick(1);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr_drop: got %b/%0d want 1/1",
               bus.overflow, bus.drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) pop();
    for (int i = 0; i < 5; i++) send_key(1'b1, 1'b0, 8'(8'h40 + i));
    checks++;
    if (bus.count !== 5'd5) begin
      errors++;
      $display("FAIL mid_pre: got %0d want 5", bus.count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
      errors++;
      $display("FAIL mid_async: got %b/%0d want 1/0",
               bus.empty, bus.count);
    end
    checks++;
    if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_diag: got %b/%0d want 0/0",
               bus.overflow, bus.drop_cnt);
    end
    tick(2);
    reset = 1'b0;
    tick(3);
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_rearm: got empty=%b want 1", bus.empty);
    end
    send_key(1'b0, 1'b1, 8'hF0);
    checks++;
    if (bus.count !== 5'd1 || bus.dout !== 10'h1F0) begin
      errors++;
      $display("FAIL mid_one: got %0d/%h want 1/1f0",
               bus.count, bus.dout);
    end
    tick(4);
    checks++;
    if (bus.count !== 5'd1) begin
      errors++;
      $display("FAIL mid_exact: got %0d want 1", bus.count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
